// File: rtl/dmem_ctrl_if.sv
// dmem_ctrl_if: MEM-stage request/response bundle between the
// EX/MEM register (master) and the data-memory controller (slave).
interface dmem_ctrl_if #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
);

   logic                  req_rd;
   logic                  req_wr;
   logic [DM_ADDRESS-1:0] addr;
   logic [DATA_W-1:0]     wr_data;
   logic [2:0]            func3;
   logic [DATA_W-1:0]     rd_data;
   logic                  rd_valid;
   logic                  busy;
   logic                  misalign;

   modport master (
      output req_rd,
      output req_wr,
      output addr,
      output wr_data,
      output func3,
      input  rd_data,
      input  rd_valid,
      input  busy,
      input  misalign
   );

   modport slave (
      input  req_rd,
      input  req_wr,
      input  addr,
      input  wr_data,
      input  func3,
      output rd_data,
      output rd_valid,
      output busy,
      output misalign
   );

endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: byte-addressed MEM-stage data memory (lb/lh/lw/sb/sh/sw).
// Define MISALIGN_SPLIT_EN to split word-crossing accesses over two cycles.
module dmem_ctrl #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
) (
   input logic        clk,
   input logic        reset,
   dmem_ctrl_if.slave bus
);

   localparam int IW    = DM_ADDRESS - 2;
   localparam int WORDS = 2 ** IW;

   logic [DATA_W-1:0] mem_q [WORDS];

   logic              up_req;
   logic              up_wr;
   logic [1:0]        up_off;
   logic [IW-1:0]     up_idx;
   logic [2:0]        up_sz;
   logic              up_zext;
   logic              up_mis;
   logic              up_cross;
   logic [3:0]        up_mask;
   logic [3:0]        be_lo;
   logic [DATA_W-1:0] wd_lo;

   logic [IW-1:0]     acc_idx;
   logic [DATA_W-1:0] acc_word;
   logic [3:0]        we;
   logic [DATA_W-1:0] wr_word;

   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              mis_q, mis_d;

   // up_sz is one-hot {word, half, byte}
   assign up_req  = bus.req_rd | bus.req_wr;
   assign up_wr   = bus.req_wr;
   assign up_off  = bus.addr[1:0];
   assign up_idx  = bus.addr[DM_ADDRESS-1:2];
   assign up_zext = bus.func3[2];
   assign up_sz   = {bus.func3[1],
                     bus.func3[1:0] == 2'b01,
                     bus.func3[1:0] == 2'b00};

   always_comb begin
      up_mask  = 4'b1111;
      up_mis   = 1'b0;
      up_cross = 1'b0;
      unique case (1'b1)
         up_sz[0]: up_mask = 4'b0001;
         up_sz[1]: begin
            up_mask  = 4'b0011;
            up_mis   = up_off[0];
            up_cross = (up_off == 2'd3);
         end
         up_sz[2]: begin
            up_mis   = (up_off != 2'd0);
            up_cross = (up_off != 2'd0);
         end
      endcase
   end

   assign be_lo = up_mask << up_off;
   assign wd_lo = bus.wr_data << {up_off, 3'b000};

   function automatic logic [DATA_W-1:0] extend(
      input logic [2*DATA_W-1:0] pair,
      input logic [1:0]          off,
      input logic [1:0]          sz,
      input logic                zext
   );
      logic [DATA_W-1:0] v;
      v = DATA_W'(pair >> {off, 3'b000});
      unique case (1'b1)
         sz[0]:   v = {{24{~zext & v[7]}}, v[7:0]};
         sz[1]:   v = {{16{~zext & v[15]}}, v[15:0]};
         default: v = v;
      endcase
      return v;
   endfunction

   assign acc_word = mem_q[acc_idx];

`ifdef MISALIGN_SPLIT_EN

   localparam logic [0:0] S_IDLE   = 1'b0;
   localparam logic [0:0] S_SECOND = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [1:0]        off_q, off_d;
   logic [1:0]        sz_q, sz_d;
   logic              zext_q, zext_d;
   logic              ld_q, ld_d;
   logic [DATA_W-1:0] lo_word_q, lo_word_d;
   logic [3:0]        be_hi_q, be_hi_d;
   logic [DATA_W-1:0] wd_hi_q, wd_hi_d;
   logic [3:0]        be_hi;
   logic [DATA_W-1:0] wd_hi;

   // lanes rotated past byte 3 spill into the following word
   assign be_hi = up_mask >> (3'd4 - {1'b0, up_off});
   assign wd_hi = bus.wr_data >> (6'd32 - {1'b0, up_off, 3'b000});

   assign acc_idx = (state_q == S_SECOND) ? idx_q + IW'(1) : up_idx;
   assign bus.busy = ~reset & (state_q == S_IDLE) & up_req & up_cross;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      off_d      = off_q;
      sz_d       = sz_q;
      zext_d     = zext_q;
      ld_d       = ld_q;
      lo_word_d  = lo_word_q;
      be_hi_d    = be_hi_q;
      wd_hi_d    = wd_hi_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      mis_d      = 1'b0;
      we         = 4'b0000;
      wr_word    = wd_lo;
      unique case (state_q)
         S_SECOND: begin
            state_d = S_IDLE;
            if (ld_q) begin
               rd_data_d  = extend({acc_word, lo_word_q},
                                   off_q, sz_q, zext_q);
               rd_valid_d = 1'b1;
            end else begin
               we      = be_hi_q;
               wr_word = wd_hi_q;
            end
         end
         default: begin
            if (up_req) begin
               mis_d = up_mis;
               if (up_wr) begin
                  we = be_lo;
               end
               if (up_cross) begin
                  state_d   = S_SECOND;
                  idx_d     = up_idx;
                  off_d     = up_off;
                  sz_d      = up_sz[1:0];
                  zext_d    = up_zext;
                  ld_d      = ~up_wr;
                  lo_word_d = acc_word;
                  be_hi_d   = be_hi;
                  wd_hi_d   = wd_hi;
               end else if (!up_wr) begin
                  rd_data_d  = extend({{DATA_W{1'b0}}, acc_word},
                                      up_off, up_sz[1:0], up_zext);
                  rd_valid_d = 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      idx_q     <= idx_d;
      off_q     <= off_d;
      sz_q      <= sz_d;
      zext_q    <= zext_d;
      ld_q      <= ld_d;
      lo_word_q <= lo_word_d;
      be_hi_q   <= be_hi_d;
      wd_hi_q   <= wd_hi_d;
   end

`else

   assign acc_idx  = up_idx;
   assign bus.busy = 1'b0;

   // crossing stores are dropped, crossing loads return zero
   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      mis_d      = 1'b0;
      we         = 4'b0000;
      wr_word    = wd_lo;
      if (up_req) begin
         mis_d = up_mis;
         if (up_wr) begin
            if (!up_cross) begin
               we = be_lo;
            end
         end else begin
            rd_valid_d = 1'b1;
            rd_data_d  = up_cross ? '0
                       : extend({{DATA_W{1'b0}}, acc_word},
                                up_off, up_sz[1:0], up_zext);
         end
      end
   end

`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         mis_q      <= 1'b0;
      end else begin
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         mis_q      <= mis_d;
      end
   end

   // contents survive reset; a write in a reset cycle is abandoned
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int b = 0; b < 4; b++) begin
            if (we[b]) begin
               mem_q[acc_idx][8*b +: 8] <= wr_word[8*b +: 8];
            end
         end
      end
   end

   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.misalign = mis_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: vector table, multi-cycle corner sequences and a
// randomized run against a byte-array reference model.
module tb_dmem_ctrl;

`ifdef MISALIGN_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   typedef struct {
      logic        rd;
      logic        wr;
      logic [8:0]  addr;
      logic [31:0] wd;
      logic [2:0]  f3;
      logic        e_busy;
      logic        e_valid;
      logic [31:0] e_data;
      logic        e_mis;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   int          n_chk = 0;
   int          n_fail = 0;
   logic        o_busy, o_valid, o_mis;
   logic [31:0] o_data;
   logic [7:0]  mem_m [512];
   vec_t        vt [16];

   logic        p_valid, p_mis;
   logic [31:0] p_data, rd_m, old_m;
   logic        r_rd, r_wr, r_cross, r_mis;
   logic [8:0]  r_a;
   logic [31:0] r_d;
   logic [2:0]  r_f;

   dmem_ctrl_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

   dmem_ctrl #(.DM_ADDRESS(9), .DATA_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      end
   endtask

   // one cycle: drive at posedge+1, sample mid-cycle at negedge
   task automatic cyc(input logic rd, input logic wr, input logic [8:0] a,
                      input logic [31:0] d, input logic [2:0] f);
      bus.req_rd  = rd;
      bus.req_wr  = wr;
      bus.addr    = a;
      bus.wr_data = d;
      bus.func3   = f;
      @(negedge clk);
      o_busy  = bus.busy;
      o_valid = bus.rd_valid;
      o_data  = bus.rd_data;
      o_mis   = bus.misalign;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 9'h0, 32'h0, 3'd0);
   endtask

   function automatic int size_of(input logic [2:0] f);
      return f[1] ? 4 : (f[0] ? 2 : 1);
   endfunction

   function automatic logic crosses(input logic [8:0] a, input logic [2:0] f);
      return (int'(a) % 4) + size_of(f) > 4;
   endfunction

   function automatic logic [31:0] model_load(input logic [8:0] a,
                                              input logic [2:0] f);
      int n;
      logic [31:0] v;
      n = size_of(f);
      v = 32'h0;
      if (crosses(a, f) && !SPLIT) return 32'h0;
      for (int k = 0; k < n; k++) v[8*k +: 8] = mem_m[(int'(a) + k) % 512];
      if (!f[2] && n < 4 && v[8*n-1])
         for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
      return v;
   endfunction

   task automatic model_store(input logic [8:0] a, input logic [2:0] f,
                              input logic [31:0] d);
      if (crosses(a, f) && !SPLIT) return;
      for (int k = 0; k < size_of(f); k++)
         mem_m[(int'(a) + k) % 512] = d[8*k +: 8];
   endtask

   task automatic chk_pend(input string nm);
      chk({nm, " rd_valid"}, {31'b0, o_valid}, {31'b0, p_valid});
      chk({nm, " rd_data"}, o_data, p_data);
      chk({nm, " misalign"}, {31'b0, o_mis}, {31'b0, p_mis});
   endtask

   initial begin
      vt[0]  = '{1'b0, 1'b1, 9'h010, 32'hDEADBEEF, 3'd2, 1'b0, 1'b0, 32'h00000000, 1'b0};
      vt[1]  = '{1'b1, 1'b0, 9'h010, 32'h0,        3'd2, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0};
      vt[2]  = '{1'b0, 1'b1, 9'h020, 32'h80FF7F01, 3'd2, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0};
      vt[3]  = '{1'b1, 1'b0, 9'h023, 32'h0,        3'd0, 1'b0, 1'b1, 32'hFFFFFF80, 1'b0};
      vt[4]  = '{1'b1, 1'b0, 9'h023, 32'h0,        3'd4, 1'b0, 1'b1, 32'h00000080, 1'b0};
      vt[5]  = '{1'b1, 1'b0, 9'h022, 32'h0,        3'd1, 1'b0, 1'b1, 32'hFFFF80FF, 1'b0};
      vt[6]  = '{1'b1, 1'b0, 9'h021, 32'h0,        3'd5, 1'b0, 1'b1, 32'h0000FF7F, 1'b1};
      vt[7]  = '{1'b0, 1'b1, 9'h040, 32'h0,        3'd2, 1'b0, 1'b0, 32'h0000FF7F, 1'b0};
      vt[8]  = '{1'b1, 1'b1, 9'h040, 32'h1234565A, 3'd0, 1'b0, 1'b0, 32'h0000FF7F, 1'b0};
      vt[9]  = '{1'b1, 1'b0, 9'h040, 32'h0,        3'd4, 1'b0, 1'b1, 32'h0000005A, 1'b0};
      vt[10] = '{1'b0, 1'b1, 9'h041, 32'hCAFEBEEF, 3'd1, 1'b0, 1'b0, 32'h0000005A, 1'b1};
      vt[11] = '{1'b1, 1'b0, 9'h040, 32'h0,        3'd2, 1'b0, 1'b1, 32'h00BEEF5A, 1'b0};
      vt[12] = '{1'b1, 1'b0, 9'h042, 32'h0,        3'd1, 1'b0, 1'b1, 32'h000000BE, 1'b0};
      vt[13] = '{1'b0, 1'b1, 9'h043, 32'h00000080, 3'd0, 1'b0, 1'b0, 32'h000000BE, 1'b0};
      vt[14] = '{1'b1, 1'b0, 9'h042, 32'h0,        3'd1, 1'b0, 1'b1, 32'hFFFF80BE, 1'b0};
      vt[15] = '{1'b1, 1'b0, 9'h040, 32'h0,        3'd3, 1'b0, 1'b1, 32'h80BEEF5A, 1'b0};

      reset       = 1'b1;
      bus.req_rd  = 1'b0;
      bus.req_wr  = 1'b0;
      bus.addr    = '0;
      bus.wr_data = '0;
      bus.func3   = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      idle();
      chk("reset rd_data", o_data, 32'h0);
      chk("reset rd_valid", {31'b0, o_valid}, 32'h0);
      chk("reset misalign", {31'b0, o_mis}, 32'h0);
      chk("reset busy", {31'b0, o_busy}, 32'h0);

      for (int i = 0; i < 16; i++) begin
         cyc(vt[i].rd, vt[i].wr, vt[i].addr, vt[i].wd, vt[i].f3);
         chk($sformatf("vec%0d busy", i), {31'b0, o_busy}, {31'b0, vt[i].e_busy});
         idle();
         chk($sformatf("vec%0d rd_valid", i), {31'b0, o_valid}, {31'b0, vt[i].e_valid});
         chk($sformatf("vec%0d rd_data", i), o_data, vt[i].e_data);
         chk($sformatf("vec%0d misalign", i), {31'b0, o_mis}, {31'b0, vt[i].e_mis});
      end

      // store then load of the same word on the very next cycle
      cyc(1'b0, 1'b1, 9'h030, 32'h13579BDF, 3'd2);
      cyc(1'b1, 1'b0, 9'h030, 32'h0, 3'd2);
      idle();
      chk("wr-rd rd_data", o_data, 32'h13579BDF);
      chk("wr-rd rd_valid", {31'b0, o_valid}, 32'h1);

      // crossing store at 0x0E
      cyc(1'b0, 1'b1, 9'h00C, 32'h0, 3'd2);
      cyc(1'b0, 1'b1, 9'h010, 32'h0, 3'd2);
      cyc(1'b0, 1'b1, 9'h00E, 32'h11223344, 3'd2);
      chk("xst busy N", {31'b0, o_busy}, {31'b0, SPLIT});
      cyc(1'b0, SPLIT, 9'h00E, 32'h11223344, 3'd2);
      chk("xst busy N+1", {31'b0, o_busy}, 32'h0);
      chk("xst misalign N+1", {31'b0, o_mis}, 32'h1);
      idle();
      chk("xst misalign N+2", {31'b0, o_mis}, 32'h0);
      cyc(1'b1, 1'b0, 9'h00C, 32'h0, 3'd2);
      idle();
      chk("xst word 0x0C", o_data, SPLIT ? 32'h33440000 : 32'h0);
      cyc(1'b1, 1'b0, 9'h010, 32'h0, 3'd2);
      idle();
      chk("xst word 0x10", o_data, SPLIT ? 32'h00001122 : 32'h0);

      // crossing load at 0x1FF wraps to byte 0
      cyc(1'b0, 1'b1, 9'h1FC, 32'hAA000000, 3'd2);
      cyc(1'b0, 1'b1, 9'h000, 32'h00030201, 3'd2);
      cyc(1'b1, 1'b0, 9'h1FF, 32'h0, 3'd2);
      chk("wrap busy N", {31'b0, o_busy}, {31'b0, SPLIT});
      cyc(SPLIT, 1'b0, 9'h1FF, 32'h0, 3'd2);
      chk("wrap rd_valid N+1", {31'b0, o_valid}, {31'b0, !SPLIT});
      chk("wrap rd_data N+1", o_data, SPLIT ? 32'h00001122 : 32'h0);
      chk("wrap misalign N+1", {31'b0, o_mis}, 32'h1);
      idle();
      chk("wrap rd_valid N+2", {31'b0, o_valid}, {31'b0, SPLIT});
      chk("wrap rd_data N+2", o_data, SPLIT ? 32'h030201AA : 32'h0);

      // crossing store at 0x06 with reset during its second half
      cyc(1'b0, 1'b1, 9'h004, 32'h0, 3'd2);
      cyc(1'b0, 1'b1, 9'h008, 32'h0, 3'd2);
      cyc(1'b1, 1'b0, 9'h000, 32'h0, 3'd2);
      idle();
      chk("rst-pre rd_data", o_data, 32'h00030201);
      cyc(1'b0, 1'b1, 9'h006, 32'hA1B2C3D4, 3'd2);
      chk("rst busy N", {31'b0, o_busy}, {31'b0, SPLIT});
      reset = 1'b1;
      cyc(1'b0, SPLIT, 9'h006, 32'hA1B2C3D4, 3'd2);
      chk("rst misalign N+1", {31'b0, o_mis}, 32'h1);
      reset = 1'b0;
      idle();
      chk("rst rd_data", o_data, 32'h0);
      chk("rst rd_valid", {31'b0, o_valid}, 32'h0);
      chk("rst misalign", {31'b0, o_mis}, 32'h0);
      chk("rst busy", {31'b0, o_busy}, 32'h0);
      cyc(1'b1, 1'b0, 9'h005, 32'h0, 3'd2);
      chk("rst idle busy", {31'b0, o_busy}, {31'b0, SPLIT});
      cyc(SPLIT, 1'b0, 9'h005, 32'h0, 3'd2);
      idle();
      chk("rst lw 0x05 rd_valid", {31'b0, o_valid}, {31'b0, SPLIT});
      chk("rst lw 0x05 rd_data", o_data, SPLIT ? 32'h00C3D400 : 32'h0);
      cyc(1'b1, 1'b0, 9'h004, 32'h0, 3'd2);
      idle();
      chk("rst word 0x04", o_data, SPLIT ? 32'hC3D40000 : 32'h0);
      cyc(1'b1, 1'b0, 9'h008, 32'h0, 3'd2);
      idle();
      chk("rst word 0x08", o_data, 32'h0);
      chk("rst word 0x08 rd_valid", {31'b0, o_valid}, 32'h1);

      // randomized run against the byte-array model
      reset = 1'b1;
      idle();
      reset = 1'b0;
      p_valid = 1'b0;
      p_data  = 32'h0;
      p_mis   = 1'b0;
      rd_m    = 32'h0;
      for (int w = 0; w < 128; w++) begin
         r_d = $urandom;
         cyc(1'b0, 1'b1, 9'(w * 4), r_d, 3'd2);
         chk("fill busy", {31'b0, o_busy}, 32'h0);
         chk_pend("fill");
         model_store(9'(w * 4), 3'd2, r_d);
         p_valid = 1'b0;
         p_mis   = 1'b0;
      end
      for (int i = 0; i < 600; i++) begin
         r_rd = 1'($urandom_range(0, 1));
         r_wr = 1'($urandom_range(0, 1));
         r_a  = 9'($urandom_range(0, 511));
         r_d  = $urandom;
         r_f  = 3'($urandom_range(0, 7));
         r_cross = crosses(r_a, r_f);
         r_mis   = (r_rd | r_wr) && (int'(r_a) % size_of(r_f) != 0);
         cyc(r_rd, r_wr, r_a, r_d, r_f);
         chk("rand busy", {31'b0, o_busy},
             {31'b0, (r_rd | r_wr) & r_cross & SPLIT});
         chk_pend("rand");
         old_m   = rd_m;
         p_valid = 1'b0;
         if (r_wr) begin
            model_store(r_a, r_f, r_d);
         end else if (r_rd) begin
            rd_m    = model_load(r_a, r_f);
            p_valid = 1'b1;
         end
         p_data = rd_m;
         p_mis  = r_mis;
         if ((r_rd | r_wr) && r_cross && SPLIT) begin
            cyc(r_rd, r_wr, r_a, r_d, r_f);
            chk("rand second busy", {31'b0, o_busy}, 32'h0);
            chk("rand second rd_valid", {31'b0, o_valid}, 32'h0);
            chk("rand second rd_data", o_data, old_m);
            chk("rand second misalign", {31'b0, o_mis}, 32'h1);
            p_mis = 1'b0;
         end
      end
      idle();
      chk_pend("rand last");

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Byte-addressed data-memory controller for the MEM stage of the 5-stage RISC-V pipeline. It is fed directly by the EX/MEM pipeline register and produces the load data captured by MEM/WB. It supports byte, half-word and word loads and stores using func3 width/sign semantics. Accesses that cross a 32-bit word boundary are split into two sequential word accesses, and the pipeline is stalled for one cycle while this happens.

## Interface
- DM_ADDRESS, 9: byte-address width; the memory holds 2^DM_ADDRESS bytes, organised as 2^(DM_ADDRESS-2) words.
- DATA_W, 32: data width. Only 32 is supported.

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- req_rd  in  1  load request (C.MemRead)
- req_wr  in  1  store request (C.MemWrite)
- addr  in  DM_ADDRESS  byte address (C.Alu_Result[8:0])
- wr_data  in  DATA_W  store data, right-aligned (C.RD_Two)
- func3  in  3  bits [1:0] give width: 00 = byte, 01 = half, 1x = word. Bit 2 = 1 selects zero-extend on loads.
- rd_data  out  DATA_W  extended load result. Registered; holds its value until the next load completes.
- rd_valid  out  1  one-cycle pulse when rd_data is updated
- busy  out  1  combinational stall request to the pipeline
- misalign  out  1  one-cycle registered pulse for any access with a nonzero low address offset for its width

## Operation
- An access is "crossing" when:
  - width is half and addr[1:0] = 3, or
  - width is word and addr[1:0] ≠ 0.
- Non-crossing misaligned accesses (for example, a half access at offset 1) complete in a single word access.
- If req_rd and req_wr are both high, the store wins. No rd_valid is produced.
- State machine:
  - IDLE:
    - Non-crossing request: access word addr[DM_ADDRESS-1:2] at the edge. Stay in IDLE.
    - Crossing request: assert busy combinationally. At the edge, access the first word, latch the request (address, data, width, type), and go to SECOND.
  - SECOND:
    - busy = 0. The upstream request, still being held, is treated as already consumed and is ignored.
    - At the edge, access word index + 1, then return to IDLE.
    - The word index wraps modulo 2^(DM_ADDRESS-2), so byte 511 is followed by byte 0.
- Stores:
  - Per-byte write enables are derived from offset and width.
  - Bytes of wr_data are rotated left by 8·addr[1:0] bits.
  - Lanes falling past the word boundary are written to the second word.
- Loads:
  - Bytes are gathered from one or two words and right-aligned.
  - Sign- or zero-extension is applied per func3[2].
- Reset:
  - Forces IDLE and clears rd_data, rd_valid and misalign to 0.
  - Abandons any pending second half. If the first half of a store was already written, it remains written.
  - Memory contents are not cleared by reset.

## Timing
- Reset values: rd_data = 0, rd_valid = 0, misalign = 0, busy = 0, state = IDLE.
- Non-crossing load presented in cycle N: rd_data and rd_valid appear in cycle N+1.
- Non-crossing store presented in cycle N: committed at the edge ending cycle N.
- Crossing access presented in cycle N:
  - busy = 1 in cycle N only.
  - The upstream holds the request through cycle N+1.
  - The second half completes at the edge ending cycle N+1.
  - For a load, rd_valid is in cycle N+2.
- misalign pulses in cycle N+1 for a misaligned access presented in cycle N.
- Store followed by a load to the same word in the next cycle returns the new data (write-then-read ordering).

## Configuration
- Macro: MISALIGN_SPLIT_EN.
- Defined: crossing accesses are split into two word accesses, as described above.
- Undefined:
  - busy is tied to 0 and the SECOND state is not compiled in.
  - A crossing store writes nothing.
  - A crossing load returns rd_data = 0 with rd_valid in cycle N+1.
  - misalign still pulses.

## Test plan
- sw 0xDEADBEEF @0x10, then lw @0x10 → rd_data = 0xDEADBEEF, rd_valid one cycle later, misalign = 0.
- Word 0x20 = 0x80FF7F01: lb @0x23 → 0xFFFFFF80; lbu @0x23 → 0x00000080; lh @0x22 → 0xFFFF80FF; lhu @0x21 → 0x0000FF7F with misalign = 1 and no busy.
- sw 0x11223344 @0x0E, then lw @0x0C and lw @0x10 → 0x33440000 and 0x00001122. busy is high exactly one cycle, misalign pulses.
- lw @0x1FF with byte 0x1FF = 0xAA and bytes 0x000–0x002 = 0x01, 0x02, 0x03 → 0x030201AA after the wrap, rd_valid in cycle N+2.
- Crossing store at 0x06, reset asserted in the SECOND cycle → the first word is modified, the second word is unchanged, state returns to IDLE, and outputs are 0.
- req_rd = req_wr = 1, sb 0x5A @0x40 → byte 0x40 = 0x5A, no rd_valid. With the macro undefined, lw @0x41 → rd_data = 0, busy never asserted.
